// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared floating-point helpers: exponent bias, field
//               extraction for {sign, exp, mant} words and the sequencer
//               state type used by the iterative FP units.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // Sequencer states shared by the iterative FP datapaths
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_NORM   = 2'd2,
        S_DONE   = 2'd3
    } fp_state_t;

    // Exponent bias for an e-bit exponent field
    function automatic int fp_bias(input int e);
        return (1 << (e - 1)) - 1;
    endfunction

    // Sign bit: the MSB of an n-bit word
    function automatic logic fp_sign(input logic [63:0] x, input int n);
        return x[n-1];
    endfunction

    // Biased exponent field, right-aligned
    function automatic logic [63:0] fp_exp(input logic [63:0] x, input int n,
                                           input int e, input int s);
        return (x >> (n - e - s)) & ((64'd1 << e) - 64'd1);
    endfunction

    // Mantissa field (without the hidden bit), right-aligned
    function automatic logic [63:0] fp_mant(input logic [63:0] x, input int n,
                                            input int e, input int s);
        return x & ((64'd1 << (n - e - s)) - 64'd1);
    endfunction

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fdiv_mant_core.sv
`default_nettype none
// ============================================================================
// Module      : fdiv_mant_core
// Description : Iterative restoring divider for {1,mant1} / {1,mant2}.
//               One quotient bit per cycle, M+2 iterations, MSB first, so
//               quot[M+1] is the integer bit of the quotient.
// Revision    : 1.0 - initial release
// ============================================================================
module fdiv_mant_core #(
    parameter int M = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] mant1,
    input  logic [M-1:0] mant2,
    output logic [M+1:0] quot,
    output logic         done
);

    localparam int            c_CW      = $clog2(M + 2);
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(M + 1);
    localparam logic [c_CW-1:0] c_PRE   = c_CW'(M);

    logic [M+1:0]    r_rem;
    logic [M+1:0]    r_div;
    logic [M+1:0]    r_quot;
    logic [c_CW-1:0] r_cnt;
    logic            r_run;
    logic            r_done;

    logic            w_ge;
    logic [M+1:0]    w_rem_sub;

    // Restoring step: subtract only when the divisor fits
    assign w_ge      = (r_rem >= r_div);
    assign w_rem_sub = w_ge ? (r_rem - r_div) : r_rem;

    // Load on start, then iterate until the last quotient bit is produced.
    // r_done is high during the cycle that performs the final iteration so
    // the sequencer can leave DIVIDE on exactly that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_rem  <= {2'b01, mant1};
            r_div  <= {2'b01, mant2};
            r_quot <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_run) begin
            r_rem  <= w_rem_sub << 1;
            r_quot <= {r_quot[M:0], w_ge};
            r_cnt  <= r_cnt + 1'b1;
            r_done <= (r_cnt == c_PRE);
            if (r_cnt == c_LAST) begin
                r_run <= 1'b0;
            end
        end
    end

    assign quot = r_quot;
    assign done = r_done;

endmodule : fdiv_mant_core
`default_nettype wire

// File: rtl/fdiv.sv
`default_nettype none
// ============================================================================
// Module      : fdiv
// Description : Iterative floating-point divider. Sequencer, exponent path,
//               special cases and result register; the mantissa quotient
//               comes from fdiv_mant_core. Truncating, fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fdiv
    import fp_pkg::*;
#(
    parameter int N = 32,
    parameter int E = 8,
    parameter int S = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] op1,
    input  logic [N-1:0] op2,
    output logic         busy,
    output logic         res_val,
    output logic [N-1:0] res
);

    localparam int c_M  = N - E - S;
    localparam int c_EW = E + 2;

    localparam logic signed [c_EW-1:0] c_BIAS  = c_EW'(fp_bias(E));
    localparam logic signed [c_EW-1:0] c_EMAX  = c_EW'((1 << E) - 1);
    localparam logic signed [c_EW-1:0] c_EZERO = '0;
    localparam logic signed [c_EW-1:0] c_EONE  = c_EW'(1);

    fp_state_t               r_state;
    logic                    r_sign;
    logic                    r_zero1;
    logic                    r_zero2;
    logic signed [c_EW-1:0]  r_exp;
    logic signed [c_EW-1:0]  r_exp_n;
    logic [c_M-1:0]          r_mant_n;

    logic                    w_accept;
    logic                    w_sign1;
    logic                    w_sign2;
    logic [E-1:0]            w_exp1;
    logic [E-1:0]            w_exp2;
    logic [c_M-1:0]          w_mant1;
    logic [c_M-1:0]          w_mant2;
    logic signed [c_EW-1:0]  w_exp_raw;
    logic [c_M+1:0]          w_quot;
    logic                    w_core_done;
    logic [c_M-1:0]          w_mant_norm;
    logic signed [c_EW-1:0]  w_exp_norm;
    logic [S-1:0]            w_sign_field;
    logic [N-1:0]            w_res;

    // A new request is taken when idle or on the edge that leaves DONE
    assign w_accept = en && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign w_sign1 = fp_sign(64'(op1), N);
    assign w_sign2 = fp_sign(64'(op2), N);
    assign w_exp1  = E'(fp_exp(64'(op1), N, E, S));
    assign w_exp2  = E'(fp_exp(64'(op2), N, E, S));
    assign w_mant1 = c_M'(fp_mant(64'(op1), N, E, S));
    assign w_mant2 = c_M'(fp_mant(64'(op2), N, E, S));

    // Unnormalised result exponent, wide and signed so under/overflow is visible
    assign w_exp_raw = $signed({2'b00, w_exp1}) - $signed({2'b00, w_exp2}) + c_BIAS;

    fdiv_mant_core #(
        .M     (c_M)
    ) u_mant_core (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .mant1 (w_mant1),
        .mant2 (w_mant2),
        .quot  (w_quot),
        .done  (w_core_done)
    );

    // Quotient lies in (0.5, 2): shift out the integer bit or adjust exponent
    assign w_mant_norm = w_quot[c_M+1] ? w_quot[c_M:1] : w_quot[c_M-1:0];
    assign w_exp_norm  = w_quot[c_M+1] ? r_exp : (r_exp - c_EONE);

    assign w_sign_field = S'(r_sign);

    // Final result with special cases applied in priority order
    always_comb begin
        w_res = '0;
        if (r_zero1) begin
            w_res = {w_sign_field, {E{1'b0}}, {c_M{1'b0}}};
        end else if (r_zero2) begin
            w_res = {w_sign_field, {E{1'b1}}, {c_M{1'b0}}};
        end else if (r_exp_n <= c_EZERO) begin
            w_res = {w_sign_field, {E{1'b0}}, {c_M{1'b0}}};
        end else if (r_exp_n >= c_EMAX) begin
            w_res = {w_sign_field, {E{1'b1}}, {c_M{1'b0}}};
        end else begin
            w_res = {w_sign_field, r_exp_n[E-1:0], r_mant_n};
        end
    end

    // Sequencer with operand capture and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            busy     <= 1'b0;
            res_val  <= 1'b0;
            res      <= '0;
            r_sign   <= 1'b0;
            r_zero1  <= 1'b0;
            r_zero2  <= 1'b0;
            r_exp    <= '0;
            r_exp_n  <= '0;
            r_mant_n <= '0;
        end else begin
            res_val <= 1'b0;
            if (w_accept) begin
                r_sign  <= w_sign1 ^ w_sign2;
                r_zero1 <= (w_exp1 == '0) && (w_mant1 == '0);
                r_zero2 <= (w_exp2 == '0) && (w_mant2 == '0);
                r_exp   <= w_exp_raw;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_DIVIDE;
                        busy    <= 1'b1;
                    end
                end
                S_DIVIDE: begin
                    if (w_core_done) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_mant_n <= w_mant_norm;
                    r_exp_n  <= w_exp_norm;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    res     <= w_res;
                    res_val <= 1'b1;
                    if (en) begin
                        r_state <= S_DIVIDE;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : fdiv
`default_nettype wire
